// File: rtl/dibit_pack_arbiter.sv
// dibit_pack_arbiter
//   Round-robin arbiter that shares one 2-bit-to-byte packer between N_REQ
//   dibit sources. A winner gets a whole 4-beat packet of contiguous din_en
//   beats. A one-cycle din_en gap follows every packet so the packer's beat
//   counter realigns. Each packed byte is tagged with the ID of its source.
//
// Ports
//   clk, rst_n    clock, async active-low reset (also resets the packer)
//   en            arbitration enable; a packet in flight always completes
//   req           per-source request level, sampled only at arbitration
//   din_flat      source i dibit on bits [2i+1:2i]
//   ack           one-hot; source i's dibit is consumed this cycle
//   pk_din        packer din: granted dibit during XFER, 0 otherwise
//   pk_din_en     packer din_en: high only during XFER
//   pk_dout_en    packer dout_en
//   out_valid     copy of pk_dout_en; qualifies packer dout and out_id
//   out_id        source ID of the byte flagged by out_valid
//   busy          high in XFER or GAP

// Per-source lane: forwards ack and gates the dibit onto the shared mux.
module dibit_pack_arbiter_lane (
  input  logic       sel,
  input  logic [1:0] dibit,
  output logic       ack,
  output logic [1:0] dibit_q
);
  assign ack     = sel;
  assign dibit_q = sel ? dibit : 2'b00;
endmodule

module dibit_pack_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] din_flat,
  output logic [N_REQ-1:0]   ack,
  output logic [1:0]         pk_din,
  output logic               pk_din_en,
  input  logic               pk_dout_en,
  output logic               out_valid,
  output logic [ID_W-1:0]    out_id,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t                  state;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         gnt_id;
  logic [1:0]              beat_cnt;

  logic [ID_W-1:0]         win_id;
  logic [ID_W-1:0]         nxt_ptr;
  logic                    win_found;
  logic                    grant;
  logic [ID_W:0]           idx;
  logic                    xfer;

  logic [N_REQ-1:0][1:0]   din_v;
  logic [N_REQ-1:0]        lane_sel;
  logic [N_REQ-1:0][1:0]   lane_dibit;

  assign din_v = din_flat;

  // Scan from rr_ptr upward, modulo N_REQ; first set request wins.
  // idx is one bit wider so rr_ptr+k never overflows before the wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!win_found && req[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  assign nxt_ptr = (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + ID_W'(1);
  assign grant   = en && win_found && (state == IDLE || state == GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      beat_cnt <= '0;
      out_id   <= '0;
    end else if (grant) begin
      gnt_id   <= win_id;
      rr_ptr   <= nxt_ptr;
      beat_cnt <= '0;
      state    <= XFER;
    end else begin
      case (state)
        XFER: begin
          beat_cnt <= beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) begin
            // Tag lands together with the packer's dout_en next cycle.
            out_id <= gnt_id;
            state  <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign xfer      = (state == XFER);
  assign pk_din_en = xfer;
  assign busy      = (state != IDLE);
  assign out_valid = pk_dout_en;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) lane_sel[i] = xfer && (gnt_id == ID_W'(i));
  end

  dibit_pack_arbiter_lane u_lane [N_REQ-1:0] (
    .sel     (lane_sel),
    .dibit   (din_v),
    .ack     (ack),
    .dibit_q (lane_dibit)
  );

  // Only the selected lane is non-zero, so an OR acts as the mux.
  always_comb begin
    pk_din = 2'b00;
    for (int i = 0; i < N_REQ; i++) pk_din = pk_din | lane_dibit[i];
  end

endmodule

// File: doc/dibit_pack_arbiter.md
# dibit_pack_arbiter

Round-robin arbiter and sequencer that shares one 2-bit-to-byte packer (`din`/`din_en` in, `dout`/`dout_en` out) between `N_REQ` dibit sources. It grants one requester a whole 4-beat packet and drives the packer's `din`/`din_en` with contiguous beats. It forces a one-cycle `din_en` gap between packets so the packer's beat counter realigns. It tags each packed byte with the source ID so downstream logic can route it.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of the source ID, equal to clog2(`N_REQ`).
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low; clock `clk`. The same `rst_n` also resets the packer.
- `en`  in  1: arbitration enable; when low, no new grants; a packet in flight completes.
- `req`  in  N_REQ: per-source request level; sampled only at arbitration.
- `din_flat`  in  2*N_REQ: source i dibit on bits [2i+1:2i].
- `ack`  out  N_REQ: one-hot; `ack[i]`=1 in each cycle source i's current dibit is consumed.
- `pk_din`  out  2: to packer `din`; equals the granted source's dibit during XFER, 0 otherwise.
- `pk_din_en`  out  1: to packer `din_en`; high only in XFER.
- `pk_dout_en`  in  1: from packer `dout_en`.
- `out_valid`  out  1: equals `pk_dout_en`; qualifies packer `dout` and `out_id`.
- `out_id`  out  ID_W: source ID of the byte currently flagged by `out_valid`.
- `busy`  out  1: high in XFER or GAP.

## Operation
- FSM states:
  - IDLE: `pk_din_en`=0.
    - If `en` and any `req` bit is set: latch winner into `gnt_id`, clear `beat_cnt` → XFER.
    - Otherwise stay in IDLE.
  - XFER: `pk_din_en`=1, `pk_din`=`din_flat[gnt_id]`, `ack[gnt_id]`=1.
    - Each cycle `beat_cnt`++ (2 bits).
    - On the edge where `beat_cnt`==3: load `out_id`←`gnt_id` → GAP.
  - GAP: `pk_din_en`=0 for exactly one cycle, which resets the packer's beat counter.
    - If `en` and any `req` bit is set: arbitrate → XFER.
    - Otherwise → IDLE.
- Round-robin:
  - Search starts at `rr_ptr` and ascends modulo `N_REQ`; the first set `req` bit wins.
  - On each grant, `rr_ptr`←winner+1; winner `N_REQ`-1 wraps to 0.
- Packets are always exactly 4 beats. `req` is ignored between grant and packet end. A source dropping `req` mid-packet still has 4 beats taken.
- Requester rule: hold the current dibit until the edge ending an `ack` cycle, then present the next one. The first beat (MSB pair of the byte) must be valid in the first XFER cycle.
- Byte order is MSB-first: beat 0 → `dout`[7:6], beat 3 → `dout`[1:0].
- `out_id` holds its value until the next packet's final beat.
- `en` deasserted during XFER: the packet completes; the FSM then goes GAP → IDLE.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `gnt_id`=0, `beat_cnt`=0, `out_id`=0, `ack`=0, `pk_din`=0, `pk_din_en`=0, `busy`=0. `out_valid` follows `pk_dout_en`, which is 0 in reset.
- Grant latency: with `req` seen high in IDLE in cycle t, XFER beats occupy cycles t+1..t+4.
- Output latency: `pk_dout_en`/`out_valid` is high in cycle t+5, with `out_id` already valid in that cycle.
- Back-to-back throughput: 4 beats per 5 cycles (XFER×4, GAP×1). The next packet's first beat is at t+6.
- `ack`, `pk_din_en` and `busy` are decoded from registered state. `pk_din` is a combinational mux on registered `gnt_id`.
- Asynchronous reset mid-packet: everything clears immediately. The partial packet is dropped with no `out_valid`, and arbitration restarts from `rr_ptr`=0.

## Test plan
- Single source: `req`=0010, dibits 1,2,3,0 → `ack[1]` for 4 cycles; `pk_din_en` 4 cycles then 0; `out_valid` 1 cycle later with `dout`=0x6C, `out_id`=1.
- All four requesting continuously → grant order 0,1,2,3,0; exactly one cycle with `pk_din_en`=0 between packets; 4 bytes per 20 cycles, each `out_id` matching its source.
- Wrap-around: `req`=1001 with `rr_ptr`=3 → source 3 granted first, then source 0.
- `req[2]` dropped after beat 1, `en` dropped during XFER → packet still completes 4 beats; no further grant while `en`=0.
- `rst_n` pulsed low during beat 2 → outputs take reset values at once; no `out_valid`; the next `req` gets a clean 4-beat packet producing the correct byte.
